// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : 8N1/8N2 UART transmitter with one-entry holding register so that
//            back-to-back frames run with no idle gap on the line.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       ctrl_out_tx_has_data,
    output logic       ctrl_in_tx_ready,
    output logic       ctrl_in_tx_accept,
    output logic       ctrl_in_tx_busy,
    output logic       pin
);

    localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic        c_LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [15:0] r_baud_cnt,  w_baud_nxt;
    logic [2:0]  r_bit_idx,   w_bit_nxt;
    logic        r_stop_cnt,  w_stop_nxt;
    logic [7:0]  r_shift,     w_shift_nxt;
    logic [7:0]  r_hold,      w_hold_nxt;
    logic        r_hold_full, w_hold_full_nxt;
    logic        r_pin,       w_pin_nxt;
    logic        r_accept,    w_accept_nxt;
    logic        w_bit_end;

    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_baud_nxt      = 16'(r_baud_cnt + 16'd1);
        w_bit_nxt       = r_bit_idx;
        w_stop_nxt      = r_stop_cnt;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_pin_nxt       = r_pin;
        w_accept_nxt    = 1'b0;

        // Capture only depends on hold_full, so it never collides with a load.
        if (ctrl_out_tx_has_data && !r_hold_full) begin
            w_hold_nxt      = data_in;
            w_hold_full_nxt = 1'b1;
            w_accept_nxt    = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = 16'd0;
                w_pin_nxt  = 1'b1;
                if (r_hold_full) begin
                    w_state_nxt     = S_START;
                    w_shift_nxt     = r_hold;
                    w_hold_full_nxt = 1'b0;
                    w_pin_nxt       = 1'b0;
                    w_bit_nxt       = 3'd0;
                    w_stop_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = 16'd0;
                    w_bit_nxt   = 3'd0;
                    w_pin_nxt   = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = 16'd0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                        w_bit_nxt   = 3'd0;
                        w_stop_nxt  = 1'b0;
                        w_pin_nxt   = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_pin_nxt   = r_shift[1];
                        w_bit_nxt   = 3'(r_bit_idx + 3'd1);
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt = 16'd0;
                    if (r_stop_cnt == c_LAST_STOP) begin
                        w_stop_nxt = 1'b0;
                        // A waiting byte starts immediately, keeping frames gapless.
                        if (r_hold_full) begin
                            w_state_nxt     = S_START;
                            w_shift_nxt     = r_hold;
                            w_hold_full_nxt = 1'b0;
                            w_pin_nxt       = 1'b0;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_pin_nxt   = 1'b1;
                        end
                    end else begin
                        w_stop_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = 16'd0;
                w_pin_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_baud_cnt  <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= 8'd0;
            r_hold      <= 8'd0;
            r_hold_full <= 1'b0;
            r_pin       <= 1'b1;
            r_accept    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_baud_cnt  <= w_baud_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_stop_cnt  <= w_stop_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_pin       <= w_pin_nxt;
            r_accept    <= w_accept_nxt;
        end
    end

    assign ctrl_in_tx_ready  = ~r_hold_full;
    assign ctrl_in_tx_accept = r_accept;
    assign ctrl_in_tx_busy   = (r_state != S_IDLE);
    assign pin               = r_pin;

endmodule
`default_nettype wire
